disp_arbiter: RTL and testbench

Arbitrates ownership of the shared 4-digit seven-segment display between three frame sources: the menu scroller, the in-game readout and an alert/win-lose banner. It inserts a short blank gap on every ownership change so residue from the previous owner never reaches the digits. It then drives the display through a registered, time-multiplexed digit scan. It sits between the game state machine's display producers and the board's segment/anode pins.

---
 rtl/disp_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_disp_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// Seven-segment display arbiter: priority ownership of a 4-digit display with a
// forced blank gap between owners and a registered digit scan. Blinking: DISP_BLINK_EN.
module disp_arbiter #(
  parameter int SCAN_DIV  = 50000,
  parameter int HOLD_CYC  = 1000000,
  parameter int BLANK_CYC = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [27:0] frame0,
  input  logic [27:0] frame1,
  input  logic [27:0] frame2,
  input  logic        blink,
  output logic [2:0]  gnt,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, OWN} state_t;

  state_t         state;
  logic [27:0]    frame_q;
  logic [BW-1:0]  blank_cnt;
  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  scan_cnt;
  logic [1:0]     digit;

  logic [2:0]     winner;
  logic [27:0]    win_frame;
  logic [27:0]    own_frame;
  logic           hold_sat;
  logic           leave;
  logic [6:0]     digit_seg;
  logic           blink_mask;

  always_comb begin
    winner = 3'b000;
    if (req[2])      winner = 3'b100;
    else if (req[1]) winner = 3'b010;
    else if (req[0]) winner = 3'b001;
  end

  always_comb begin
    win_frame = 28'd0;
    case (winner)
      3'b001:  win_frame = frame0;
      3'b010:  win_frame = frame1;
      3'b100:  win_frame = frame2;
      default: win_frame = 28'd0;
    endcase
  end

  always_comb begin
    own_frame = 28'd0;
    case (gnt)
      3'b001:  own_frame = frame0;
      3'b010:  own_frame = frame1;
      3'b100:  own_frame = frame2;
      default: own_frame = 28'd0;
    endcase
  end

  // The alert source preempts immediately; other higher-priority sources wait for hold.
  always_comb begin
    hold_sat = (hold_cnt == HW'(HOLD_CYC - 1));
    leave    = ~|(req & gnt)
             | (req[2] & ~gnt[2])
             | (hold_sat & ((gnt[0] & |req[2:1]) | (gnt[1] & req[2])));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 3'b000;
      frame_q   <= 28'd0;
      blank_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt     <= 3'b000;
          frame_q <= 28'd0;
          if (|req) begin
            state     <= BLANK;
            blank_cnt <= BW'(BLANK_CYC - 1);
          end
        end
        BLANK: begin
          gnt     <= 3'b000;
          frame_q <= 28'd0;
          if (req == 3'b000) begin
            state <= IDLE;
          end else if (blank_cnt == '0) begin
            state    <= OWN;
            gnt      <= winner;
            frame_q  <= win_frame;
            hold_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end
        OWN: begin
          if (leave) begin
            state     <= BLANK;
            gnt       <= 3'b000;
            frame_q   <= 28'd0;
            blank_cnt <= BW'(BLANK_CYC - 1);
          end else begin
            frame_q <= own_frame;
            if (!hold_sat) hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= 3'b000;
          frame_q <= 28'd0;
        end
      endcase
    end
  end

`ifdef DISP_BLINK_EN
  localparam int KW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [KW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == KW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_mask = blink & blink_phase;
`else
  // blink is accepted but has no effect in this build.
  assign blink_mask = blink & 1'b0;
`endif

  always_comb begin
    digit_seg = 7'd0;
    case (digit)
      2'd0: digit_seg = frame_q[6:0];
      2'd1: digit_seg = frame_q[13:7];
      2'd2: digit_seg = frame_q[20:14];
      2'd3: digit_seg = frame_q[27:21];
      default: digit_seg = 7'd0;
    endcase
  end

  // Scan free-runs in every state; seg/an are registered from the current digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      seg      <= 7'd0;
      an       <= 4'b1111;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << digit);
      seg <= blink_mask ? 7'd0 : digit_seg;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed scenarios followed by random
// traffic, all compared against an owner/gap reference model kept in the bench.
module tb_disp_arbiter;
  localparam int SCAN_DIV  = 2;
  localparam int HOLD_CYC  = 8;
  localparam int BLANK_CYC = 2;
  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [27:0] frame0, frame1, frame2;
  logic        blink;
  logic [2:0]  gnt;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  disp_arbiter #(
    .SCAN_DIV(SCAN_DIV), .HOLD_CYC(HOLD_CYC), .BLANK_CYC(BLANK_CYC), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .blink(blink), .gnt(gnt), .seg(seg), .an(an)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the display, how many gap cycles remain, how long
  // the owner has held it, and the time since reset that drives scan and blink.
  int          m_owner = -1;
  bit          m_gap_on = 1'b0;
  int          m_gap = 0;
  int          m_held = 0;
  int          m_ticks = 0;
  logic [27:0] m_frame = 28'd0;
  logic [2:0]  m_gnt = 3'b000;
  logic [6:0]  m_seg = 7'd0;
  logic [3:0]  m_an = 4'b1111;

  function automatic logic [27:0] frame_of(input int i);
    case (i)
      0: return frame0;
      1: return frame1;
      2: return frame2;
      default: return 28'd0;
    endcase
  endfunction

  function automatic logic [6:0] dig(input logic [27:0] f, input int d);
    return f[d*7 +: 7];
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Applies one clock edge to the model using the inputs held across that edge.
  task automatic model_step();
    int  d;
    int  w;
    bit  ph;
    bit  leave;
    logic [6:0] s;
    if (rst) begin
      m_owner = -1; m_gap_on = 1'b0; m_gap = 0; m_held = 0; m_ticks = 0;
      m_frame = 28'd0; m_seg = 7'd0; m_an = 4'b1111;
    end else begin
      d  = (m_ticks / SCAN_DIV) % 4;
      ph = ((m_ticks / BLINK_DIV) % 2) == 1;
      s  = dig(m_frame, d);
`ifdef DISP_BLINK_EN
      if (blink && ph) s = 7'd0;
`else
      if (ph && 1'b0) s = 7'd0;
`endif
      m_seg = s;
      m_an  = 4'hF ^ (4'h1 << d);
      w = req[2] ? 2 : req[1] ? 1 : req[0] ? 0 : -1;
      if (m_owner >= 0) begin
        leave = !req[m_owner] || (req[2] && m_owner != 2) ||
                (w > m_owner && m_held == HOLD_CYC - 1);
        if (leave) begin
          m_owner = -1; m_gap_on = 1'b1; m_gap = BLANK_CYC - 1; m_frame = 28'd0;
        end else begin
          m_frame = frame_of(m_owner);
          if (m_held < HOLD_CYC - 1) m_held++;
        end
      end else if (m_gap_on) begin
        m_frame = 28'd0;
        if (w < 0) m_gap_on = 1'b0;
        else if (m_gap == 0) begin
          m_gap_on = 1'b0; m_owner = w; m_held = 0; m_frame = frame_of(w);
        end else m_gap--;
      end else begin
        m_frame = 28'd0;
        if (w >= 0) begin m_gap_on = 1'b1; m_gap = BLANK_CYC - 1; end
      end
      m_ticks++;
    end
    m_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
  endtask

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    chk("gnt", 28'(gnt), 28'(m_gnt));
    chk("seg", 28'(seg), 28'(m_seg));
    chk("an", 28'(an), 28'(m_an));
  endtask

  task automatic wait_gnt(input logic [2:0] exp, input int budget);
    for (int i = 0; i < budget && gnt !== exp; i++) tick();
    chk("wait_gnt", 28'(gnt), 28'(exp));
  endtask

  logic [6:0] tbl [4];
  int idx;
  int zero_cnt;

  initial begin
    tbl[0] = 7'h77; tbl[1] = 7'h7C; tbl[2] = 7'h39; tbl[3] = 7'h07;
    rst = 1'b1; req = 3'b000; blink = 1'b0;
    frame0 = 28'd0; frame1 = 28'd0; frame2 = 28'd0;

    // Reset state.
    tick();
    chk("rst_gnt", 28'(gnt), 28'h0);
    chk("rst_an", 28'(an), 28'hF);
    chk("rst_seg", 28'(seg), 28'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("an_first", 28'(an), 28'b1110);

    // Menu request: grant three edges later, then the scan walks the digits.
    frame0 = 28'h0EE7E77;
    req = 3'b001;
    tick(); chk("s1_gnt0", 28'(gnt), 28'h0);
    tick(); chk("s1_gnt1", 28'(gnt), 28'h0);
    tick(); chk("s1_gnt2", 28'(gnt), 28'b001);
    for (int i = 0; i < 10; i++) begin
      tick();
      idx = an_idx(an);
      chk("s1_an_onehot", 28'(idx >= 0), 28'd1);
      if (idx >= 0) chk("s1_seg", 28'(seg), 28'(tbl[idx]));
    end

    // Game request while menu hold count is 3: waits for saturation.
    req = 3'b000;
    frame1 = 28'($urandom);
    repeat (4) tick();
    req = 3'b001;
    wait_gnt(3'b001, 10);
    repeat (3) tick();
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("s2_hold_gnt", 28'(gnt), 28'b001);
    end
    tick(); chk("s2_blank_gnt0", 28'(gnt), 28'h0);
    tick(); chk("s2_blank_gnt1", 28'(gnt), 28'h0);
    chk("s2_blank_seg1", 28'(seg), 28'h0);
    tick(); chk("s2_game_gnt", 28'(gnt), 28'b010);
    chk("s2_blank_seg2", 28'(seg), 28'h0);

    // Alert preempts game at hold count 1.
    frame2 = 28'($urandom);
    tick();
    req = 3'b110;
    tick(); chk("s3_gnt0", 28'(gnt), 28'h0);
    tick(); chk("s3_gnt1", 28'(gnt), 28'h0);
    tick(); chk("s3_alert_gnt", 28'(gnt), 28'b100);
    for (int i = 0; i < 4; i++) begin
      tick();
      idx = an_idx(an);
      chk("s3_an_onehot", 28'(idx >= 0), 28'd1);
      if (idx >= 0) chk("s3_seg", 28'(seg), 28'(dig(frame2, idx)));
    end

    // Release to idle; a brief request during the gap also returns to idle.
    req = 3'b000;
    tick(); chk("s4_gnt", 28'(gnt), 28'h0);
    repeat (3) tick();
    chk("s4_seg", 28'(seg), 28'h0);
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("s4_stay_idle", 28'(gnt), 28'h0);
    end

    // Reset mid-ownership with digit index 2.
    req = 3'b010;
    wait_gnt(3'b010, 10);
    for (int i = 0; i < 20 && ((m_ticks / SCAN_DIV) % 4) != 2; i++) tick();
    rst = 1'b1;
    tick();
    chk("s5_gnt", 28'(gnt), 28'h0);
    chk("s5_an", 28'(an), 28'hF);
    chk("s5_seg", 28'(seg), 28'h0);
    rst = 1'b0;
    tick();
    chk("s5_an_restart", 28'(an), 28'b1110);

    // Blink over an all-on frame.
    frame0 = 28'hFFFFFFF;
    req = 3'b001;
    wait_gnt(3'b001, 10);
    repeat (2) tick();
    blink = 1'b1;
    tick();
    zero_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg == 7'd0) zero_cnt++;
    end
`ifdef DISP_BLINK_EN
    chk("blink_zero_cnt", 28'(zero_cnt), 28'd8);
`else
    chk("blink_zero_cnt", 28'(zero_cnt), 28'd0);
`endif
    blink = 1'b0;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) frame0 = 28'($urandom);
      if ($urandom_range(0, 3) == 0) frame1 = 28'($urandom);
      if ($urandom_range(0, 3) == 0) frame2 = 28'($urandom);
      if ($urandom_range(0, 15) == 0) blink = ~blink;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
